// File: rtl/lsu_wb_if.sv
// Bundles the execute-side request, data-memory bus and write-back/fault outputs of lsu_wb.
// No logic inside. The block itself takes the slave view; the environment takes the master view.
// Both request and memory command use valid/ready handshakes.
interface lsu_wb_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [REG_AW-1:0] req_rd;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic [REG_AW-1:0] rd_addr;
  logic [XLEN-1:0]   rd_data;
  logic              rd_web;
  logic              fault_valid;
  logic [1:0]        fault_cause;
  logic              busy;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output rd_addr, rd_data, rd_web, fault_valid, fault_cause, busy
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  rd_addr, rd_data, rd_web, fault_valid, fault_cause, busy
  );
endinterface

// File: rtl/lsu_wb.sv
// Load/store unit: one access in flight, byte-lane store formatting, load align/extend, one-cycle write-back.
// Best case: load write-back 3 cycles after accept, store done 2 cycles after accept; faults pulse 1 cycle after.
// req_ready only in IDLE; ISSUE holds the command until mem_ready; ISSUE+WAIT abandoned after TIMEOUT cycles.
module lsu_wb #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255
) (
  input logic     clk,
  input logic     rst,
  lsu_wb_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   result_q;

  logic              mem_valid_q;
  logic              mem_we_q;
  logic [XLEN-1:0]   mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [3:0]        mem_wstrb_q;
  logic              rd_web_q;
  logic              fault_valid_q;
  logic [1:0]        fault_cause_q;

  logic              f3_legal;
  logic              misal;
  logic [1:0]        acc_cause;
  logic [3:0]        acc_strb;
  logic [XLEN-1:0]   acc_wdata;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [XLEN-1:0]   load_val;
  logic [CW-1:0]     cnt_nxt;
  logic              expired;

  // Classify the offered request (illegal width beats misalignment) and pre-format its store lanes
  always_comb begin
    f3_legal  = 1'b0;
    misal     = 1'b0;
    acc_cause = 2'b00;
    acc_strb  = 4'b0000;
    acc_wdata = '0;
    if (bus.req_we) begin
      f3_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      f3_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    case (bus.req_funct3[1:0])
      2'b01:   misal = bus.req_addr[0];
      2'b10:   misal = |bus.req_addr[1:0];
      default: misal = 1'b0;
    endcase
    if (!f3_legal) begin
      acc_cause = 2'b10;
    end else if (misal) begin
      acc_cause = 2'b01;
    end
    if (bus.req_we) begin
      case (bus.req_funct3[1:0])
        2'b00: begin
          acc_strb  = 4'b0001 << bus.req_addr[1:0];
          acc_wdata = {4{bus.req_wdata[7:0]}};
        end
        2'b01: begin
          acc_strb  = 4'b0011 << bus.req_addr[1:0];
          acc_wdata = {2{bus.req_wdata[15:0]}};
        end
        default: begin
          acc_strb  = 4'b1111;
          acc_wdata = bus.req_wdata;
        end
      endcase
    end
  end

  // Select the addressed byte/halfword of the returned word and sign- or zero-extend it
  always_comb begin
    case (off_q)
      2'd0:    lane_b = bus.mem_rdata[7:0];
      2'd1:    lane_b = bus.mem_rdata[15:8];
      2'd2:    lane_b = bus.mem_rdata[23:16];
      default: lane_b = bus.mem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'b0, lane_b};
      3'b101:  load_val = {16'b0, lane_h};
      default: load_val = bus.mem_rdata;
    endcase
    cnt_nxt = cnt + CW'(1);
    expired = (cnt_nxt >= TO_LIM);
  end

  // Access sequencer: accept, issue, wait for data, write back; all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      rd_q          <= '0;
      result_q      <= '0;
      mem_valid_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= 4'b0000;
      rd_web_q      <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_cause_q <= 2'b00;
    end else begin
      rd_web_q      <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_cause_q <= 2'b00;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (acc_cause != 2'b00) begin
              fault_valid_q <= 1'b1;
              fault_cause_q <= acc_cause;
            end else begin
              we_q        <= bus.req_we;
              f3_q        <= bus.req_funct3;
              off_q       <= bus.req_addr[1:0];
              rd_q        <= bus.req_rd;
              cnt         <= '0;
              mem_valid_q <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= {bus.req_addr[XLEN-1:2], 2'b00};
              mem_wdata_q <= acc_wdata;
              mem_wstrb_q <= acc_strb;
              state       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // A handshake on the last allowed cycle still wins: memory has taken the command
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
            cnt         <= cnt_nxt;
            state       <= we_q ? S_IDLE : S_WAIT;
          end else if (expired) begin
            mem_valid_q   <= 1'b0;
            fault_valid_q <= 1'b1;
            fault_cause_q <= 2'b11;
            state         <= S_IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            result_q <= load_val;
            rd_web_q <= (rd_q != '0);
            state    <= S_WB;
          end else if (expired) begin
            fault_valid_q <= 1'b1;
            fault_cause_q <= 2'b11;
            state         <= S_IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wstrb   = mem_wstrb_q;
  assign bus.rd_addr     = rd_q;
  assign bus.rd_data     = result_q;
  assign bus.rd_web      = rd_web_q;
  assign bus.fault_valid = fault_valid_q;
  assign bus.fault_cause = fault_cause_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Scoreboard bench for lsu_wb: directed cases plus random loads/stores against a reference model.
// A second instance with a short TIMEOUT exercises the abandon path.
// Stimulus and memory are driven on the falling edge; the monitor samples 2 time units later.
module tb_lsu_wb;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_wb_if #(.XLEN(32), .REG_AW(5)) bus ();
  lsu_wb_if #(.XLEN(32), .REG_AW(5)) tbus ();

  lsu_wb #(.XLEN(32), .REG_AW(5), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  lsu_wb #(.XLEN(32), .REG_AW(5), .TIMEOUT(4)) dut_to (.clk(clk), .rst(rst), .bus(tbus));

  int n_chk = 0;
  int n_fail = 0;

  cmd_t       q_cmd[$];
  wb_t        q_wb[$];
  logic [1:0] q_flt[$];

  logic [31:0] last_addr, last_wdata, last_rd_data;
  logic [3:0]  last_strb;
  logic [1:0]  last_cause;
  logic [4:0]  last_rd;
  int          n_wb_seen = 0;
  int          n_cmd_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake, write-back and fault pulse is matched against the queues
  logic        p_vld, p_rdy, p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_strb;
  initial begin
    p_vld = 1'b0;
    p_rdy = 1'b0;
  end
  always begin : monitor
    cmd_t c;
    wb_t  w;
    logic [1:0] f;
    @(negedge clk);
    #2;
    if (rst) begin
      if (p_vld && !p_rdy) begin
        chk("mem cmd held", {bus.mem_valid, bus.mem_we == p_we, bus.mem_addr == p_addr,
            bus.mem_wdata == p_wdata, bus.mem_wstrb == p_strb}, 5'b11111);
      end
      if (bus.mem_valid && bus.mem_ready) begin
        n_cmd_seen++;
        last_addr  = bus.mem_addr;
        last_wdata = bus.mem_wdata;
        last_strb  = bus.mem_wstrb;
        if (q_cmd.size() == 0) begin
          chk("unexpected mem cmd", 1, 0);
        end else begin
          c = q_cmd.pop_front();
          chk("mem_we", bus.mem_we, c.we);
          chk("mem_addr", bus.mem_addr, c.addr);
          if (c.we) begin
            chk("mem_wstrb", bus.mem_wstrb, c.strb);
            chk("mem_wdata", bus.mem_wdata, c.wdata);
          end
        end
      end
      if (bus.rd_web) begin
        n_wb_seen++;
        last_rd_data = bus.rd_data;
        last_rd      = bus.rd_addr;
        if (q_wb.size() == 0) begin
          chk("unexpected rd_web", 1, 0);
        end else begin
          w = q_wb.pop_front();
          chk("rd_addr", bus.rd_addr, w.rd);
          chk("rd_data", bus.rd_data, w.data);
        end
      end
      if (bus.fault_valid) begin
        last_cause = bus.fault_cause;
        if (q_flt.size() == 0) begin
          chk("unexpected fault", 1, 0);
        end else begin
          f = q_flt.pop_front();
          chk("fault_cause", bus.fault_cause, f);
        end
      end else if (bus.fault_cause != 2'b00) begin
        chk("fault_cause idle", bus.fault_cause, 0);
      end
      if (bus.busy == bus.req_ready) chk("busy vs req_ready", bus.busy, ~bus.req_ready);
    end
    p_vld   = bus.mem_valid;
    p_rdy   = bus.mem_ready;
    p_we    = bus.mem_we;
    p_addr  = bus.mem_addr;
    p_wdata = bus.mem_wdata;
    p_strb  = bus.mem_wstrb;
  end

  // Reference model plus driver for one request, including the memory side
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int rdly, input int vdly);
    logic legal;
    int nb, off, cause, waited;
    logic [31:0] t;
    cmd_t c;
    wb_t  w;
    off   = int'(addr % 4);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nb    = 1 << f3[1:0];
    if (!legal)              cause = 2;
    else if (addr % nb != 0) cause = 1;
    else                     cause = 0;

    if (cause != 0) begin
      q_flt.push_back(2'(cause));
    end else begin
      c.we    = we;
      c.addr  = addr & 32'hFFFF_FFFC;
      c.strb  = 4'(((1 << nb) - 1) << off);
      c.wdata = (nb == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
                (nb == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
      q_cmd.push_back(c);
      if (!we) begin
        t = rdata >> (8 * off);
        if (nb == 1) begin
          t = t & 32'hFF;
          if (f3[2] == 1'b0 && t >= 32'h80) t = t - 32'h100;
        end else if (nb == 2) begin
          t = t & 32'hFFFF;
          if (f3[2] == 1'b0 && t >= 32'h8000) t = t - 32'h1_0000;
        end
        if (rd != 5'd0) begin
          w.rd   = rd;
          w.data = t;
          q_wb.push_back(w);
        end
      end
    end

    waited = 0;
    while (!bus.req_ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    chk("req_ready before accept", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_rd     = 5'($urandom);

    if (cause != 0) begin
      chk("fault: no mem_valid", bus.mem_valid, 0);
      chk("fault: stays idle", bus.req_ready, 1);
    end else begin
      chk("mem_valid cycle after accept", bus.mem_valid, 1);
      repeat (rdly) @(negedge clk);
      bus.mem_ready = 1'b1;
      if (!we && $urandom_range(0, 1) == 1) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
      end
      @(negedge clk);
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (we) begin
        chk("store back to idle", bus.req_ready, 1);
      end else begin
        chk("load waits for data", bus.busy, 1);
        repeat (vdly) @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        chk("rd_web in cycle after rvalid", bus.rd_web, (rd != 5'd0));
        @(negedge clk);
        chk("idle after write-back", bus.req_ready, 1);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic we;
    logic [2:0] f3;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_rd = '0; bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    tbus.req_valid = 1'b0; tbus.req_we = 1'b0; tbus.req_funct3 = 3'b0; tbus.req_addr = '0;
    tbus.req_wdata = '0; tbus.req_rd = '0; tbus.mem_ready = 1'b0; tbus.mem_rvalid = 1'b0;
    tbus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    chk("reset req_ready", bus.req_ready, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset mem outputs", {bus.mem_valid, bus.mem_we, bus.mem_wstrb}, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_wdata", bus.mem_wdata, 0);
    chk("reset rd outputs", {bus.rd_web, bus.rd_addr}, 0);
    chk("reset rd_data", bus.rd_data, 0);
    chk("reset fault", {bus.fault_valid, bus.fault_cause}, 0);
    chk("reset req_ready (short timeout)", tbus.req_ready, 1);

    // LB sign extension with slow memory
    do_req(1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 32'h80AA_BBCC, 3, 2);
    chk("LB mem_addr", last_addr, 32'h100);
    chk("LB rd_addr", last_rd, 5);
    chk("LB rd_data", last_rd_data, 32'hFFFF_FF80);
    // LHU / LH on the upper halfword
    do_req(1'b0, 3'b101, 32'h102, 32'h0, 5'd6, 32'h8001_0000, 0, 0);
    chk("LHU rd_data", last_rd_data, 32'h0000_8001);
    do_req(1'b0, 3'b001, 32'h102, 32'h0, 5'd7, 32'h8001_0000, 1, 1);
    chk("LH rd_data", last_rd_data, 32'hFFFF_8001);
    // Store lanes
    do_req(1'b1, 3'b000, 32'h201, 32'h1234_56AB, 5'd9, 32'h0, 0, 0);
    chk("SB wstrb", last_strb, 4'b0010);
    chk("SB wdata", last_wdata, 32'hABAB_ABAB);
    do_req(1'b1, 3'b001, 32'h202, 32'h0000_CAFE, 5'd9, 32'h0, 2, 0);
    chk("SH wstrb", last_strb, 4'b1100);
    chk("SH wdata", last_wdata, 32'hCAFE_CAFE);
    // Faults at accept
    do_req(1'b0, 3'b010, 32'h101, 32'h0, 5'd3, 32'h0, 0, 0);
    chk("misaligned cause", last_cause, 2'b01);
    do_req(1'b0, 3'b011, 32'h101, 32'h0, 5'd3, 32'h0, 0, 0);
    chk("illegal funct3 cause", last_cause, 2'b10);
    // Load to x0: access happens, no write-back
    n_wb_seen = 0;
    n_cmd_seen = 0;
    do_req(1'b0, 3'b010, 32'h400, 32'h0, 5'd0, 32'h1234_5678, 0, 1);
    chk("rd=0 access made", n_cmd_seen, 1);
    chk("rd=0 no write-back", n_wb_seen, 0);

    // Reset in WAIT: abandoned access leaves no trace
    begin
      cmd_t c;
      c.we = 1'b0; c.addr = 32'h300; c.strb = 4'b0; c.wdata = '0;
      q_cmd.push_back(c);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h300; bus.req_rd = 5'd7;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("pre-reset in WAIT", bus.busy, 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("reset mid-access req_ready", bus.req_ready, 1);
      chk("reset mid-access outputs", {bus.mem_valid, bus.rd_web, bus.fault_valid, bus.rd_addr}, 0);
      chk("reset mid-access mem_addr", bus.mem_addr, 0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      chk("late rvalid no rd_web", bus.rd_web, 0);
      chk("late rvalid rd_data", bus.rd_data, 0);
    end

    // Random traffic, with stray responses while idle
    for (int i = 0; i < 200; i++) begin
      logic [2:0] ld_tab [5];
      ld_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      we = 1'($urandom);
      if ($urandom_range(0, 9) < 2) f3 = 3'($urandom);
      else if (we)                  f3 = 3'($urandom_range(0, 2));
      else                          f3 = ld_tab[$urandom_range(0, 4)];
      if ($urandom_range(0, 5) == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
      end
      do_req(we, f3, $urandom & 32'h0000_FFFF, $urandom,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Timeout in ISSUE on the TIMEOUT=4 instance
    tbus.req_valid = 1'b1; tbus.req_we = 1'b0; tbus.req_funct3 = 3'b010;
    tbus.req_addr = 32'h40; tbus.req_rd = 5'd4;
    @(negedge clk);
    tbus.req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("timeout ISSUE busy cycle %0d", k), {tbus.busy, tbus.mem_valid, tbus.fault_valid}, 3'b110);
      @(negedge clk);
    end
    chk("timeout ISSUE fault", {tbus.fault_valid, tbus.fault_cause}, 3'b111);
    chk("timeout ISSUE ready", {tbus.req_ready, tbus.mem_valid}, 2'b10);
    @(negedge clk);
    chk("timeout pulse one cycle", {tbus.fault_valid, tbus.fault_cause}, 0);

    // Timeout in WAIT: command accepted, data never returns
    tbus.req_valid = 1'b1;
    tbus.mem_ready = 1'b1;
    @(negedge clk);
    tbus.req_valid = 1'b0;
    @(negedge clk);
    tbus.mem_ready = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      chk($sformatf("timeout WAIT busy cycle %0d", k), {tbus.busy, tbus.mem_valid, tbus.fault_valid}, 3'b100);
      @(negedge clk);
    end
    chk("timeout WAIT fault", {tbus.fault_valid, tbus.fault_cause, tbus.req_ready}, 4'b1111);
    tbus.mem_rvalid = 1'b1;
    tbus.mem_rdata  = 32'h1111_2222;
    @(negedge clk);
    tbus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("timeout no write-back", tbus.rd_web, 0);

    repeat (3) @(negedge clk);
    chk("pending expected commands", q_cmd.size(), 0);
    chk("pending expected write-backs", q_wb.size(), 0);
    chk("pending expected faults", q_flt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_wb.md
# lsu_wb

Load/store unit between the execute stage and the register-file write port. Accepts one memory request at a time and drives a valid/ready data-memory bus. For loads, it aligns and sign- or zero-extends the returned data, then presents it as a single-cycle register-file write (`rd_addr`/`rd_data`/`rd_web`). Misaligned requests, illegal width codes and unresponsive memory are reported as faults and produce no write-back.

## Interface
- `XLEN`, 32: data/address width. Only 32 is supported.
- `REG_AW`, 5: register address width.
- `TIMEOUT`, 255: maximum cycles spent in ISSUE+WAIT before the access is abandoned. Must be at least 2.

- `clk`  in  1  single clock; everything on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V width/sign code.
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  store data, right-aligned.
- `req_rd`  in  REG_AW  load destination register.
- `mem_valid`  out  1  memory command valid.
- `mem_ready`  in  1  memory accepts the command.
- `mem_we`  out  1  command is a write.
- `mem_addr`  out  XLEN  word-aligned address (`req_addr` with [1:0] = 0).
- `mem_wdata`  out  XLEN  store data shifted into its byte lanes.
- `mem_wstrb`  out  XLEN/8  byte enables.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  XLEN  read word.
- `rd_addr`  out  REG_AW  write-back register.
- `rd_data`  out  XLEN  write-back value.
- `rd_web`  out  1  write-back enable (one-cycle pulse).
- `fault_valid`  out  1  fault pulse.
- `fault_cause`  out  2  01 misaligned, 10 illegal funct3, 11 timeout.
- `busy`  out  1  state != IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, WB.
- **Accept:** a handshake occurs when `req_valid && req_ready` in IDLE. All `req_*` fields are captured into internal registers; the inputs are don't-care afterwards.
- **Legal funct3, loads:** 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- **Legal funct3, stores:** 000 SB, 001 SH, 010 SW.
- **Illegal funct3:** any other code is a fault with cause 10.
- **Alignment:** halfword requires addr[0]=0; word requires addr[1:0]=0. Violation is a fault with cause 01.
- **Fault precedence:** an illegal funct3 takes precedence over misalignment.
- **Fault at accept:** state stays IDLE, there is no memory access and no write-back. `fault_valid` pulses the next cycle.
- **Legal request at accept:** IDLE → ISSUE.
- **ISSUE:** `mem_valid`=1 with stable `mem_we`/`mem_addr`/`mem_wdata`/`mem_wstrb` until `mem_ready`. On `mem_valid && mem_ready`:
  - a store goes to IDLE;
  - a load goes to WAIT.
- **Store lanes:**
  - SB: strobe `0001 << addr[1:0]`, data byte replicated to all 4 lanes.
  - SH: strobe `0011 << addr[1:0]`, halfword replicated.
  - SW: strobe `1111`.
- **WAIT:** on `mem_rvalid`, select the byte or halfword at `addr[1:0]`, sign-extend (LB/LH) or zero-extend (LBU/LHU), register the result, then go to WB.
  - `mem_rvalid` in the same cycle as the ISSUE handshake is ignored; the response is taken from WAIT only.
- **WB:** for one cycle `rd_web`=1, `rd_addr`=captured rd, `rd_data`=result, then IDLE.
  - If captured rd == 0, `rd_web` stays 0. The access still occurs.
- **Timeout:**
  - The counter clears on accept and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT: fault cause 11, go to IDLE, no write-back.
  - In ISSUE, `mem_valid` drops.
- **Stray responses:** `mem_rvalid` in IDLE, ISSUE or WB is ignored.
- **Reset:** `rst`=0 at an edge forces IDLE and clears the counter and all captured registers, including mid-access. There is no write-back or fault for the abandoned access.

## Timing
- **Reset values:** `req_ready`=1 after reset release. All other outputs are 0, including `mem_*` outputs, `rd_*`, `fault_*` and `busy`.
- **`req_ready`:** combinational from state. `busy` = !`req_ready`.
- **Best-case load:** accept at cycle 0; `mem_valid` at cycle 1 with `mem_ready`=1; `mem_rvalid` at cycle 2; `rd_web` at cycle 3. The next accept is possible at cycle 4.
- **Best-case store:** accept at cycle 0; handshake at cycle 1; IDLE at cycle 2.
- **Faults:** `fault_valid`/`fault_cause` are registered, one-cycle pulses. `fault_cause` is 0 when `fault_valid`=0.
- **Back-to-back:** no overlap; at most one access is in flight.

## Test plan
- **LB sign-extension:** LB, addr 0x103, rd=5; memory returns 0x80AA_BBCC after a 3-cycle `mem_ready` delay and 2-cycle `mem_rvalid` delay → `mem_addr`=0x100; `rd_web` one cycle with `rd_addr`=5, `rd_data`=0xFFFF_FF80.
- **LHU zero-extension:** LHU, addr 0x102; returns 0x8001_0000 → `rd_data`=0x0000_8001. Repeat with LH → 0xFFFF_8001.
- **Store lanes:** SB addr 0x201, wdata 0x1234_56AB → `mem_wstrb`=0010, `mem_wdata`=0xABAB_ABAB, no `rd_web`. SH addr 0x202, wdata 0xCAFE → `mem_wstrb`=1100, `mem_wdata`=0xCAFE_CAFE.
- **Faults:** LW addr 0x101 → `fault_cause`=01, `mem_valid` never asserts. funct3=011 → `fault_cause`=10. TIMEOUT=4 with `mem_ready` held 0 → `fault_cause`=11 on the 4th busy cycle, then `req_ready`=1.
- **rd=0 load:** load with rd=0 → memory access happens, `rd_web` stays 0.
- **Reset mid-access:** `rst` low during WAIT → next cycle IDLE, outputs at reset values. A late `mem_rvalid` produces no `rd_web`.
